// File: rtl/util_cdc_pkg.sv
// Shared definitions for the CDC-channel arbiter: FSM state encoding and the
// round-robin search used by util_rr_arb.
package util_cdc_pkg;

  // state      | meaning
  // ST_IDLE    | no transfer; arbitrate when no stale ack and no done pulse
  // ST_SEND    | ch_send high, waiting for ch_rcv to rise
  // ST_RELEASE | ch_send low, waiting for ch_rcv to fall
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int RR_MAX_REQ = 16;

  // Returns the first requester at or after (last+1) mod num that is valid,
  // or -1 when nothing is requesting. last is always below num.
  function automatic int rr_search(input logic [RR_MAX_REQ-1:0] req,
                                   input int last, input int num);
    int pick;
    int idx;
    pick = -1;
    for (int k = 1; k <= RR_MAX_REQ; k++) begin
      idx = last + k;
      if (idx >= num) idx = idx - num;
      if (pick < 0 && k <= num && idx >= 0 && idx < RR_MAX_REQ) begin
        if (req[4'(idx)]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/util_rr_arb.sv
// Round-robin pick: request vector + previous winner -> one-hot grant,
// binary index and an any-request flag. Purely combinational.
module util_rr_arb
  import util_cdc_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 4
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [NUM_REQ-1:0]  grant_oh,
  output logic [ID_WIDTH-1:0] grant_idx,
  output logic                any_valid
);

  logic [RR_MAX_REQ-1:0] req_pad;
  int                    pick;

  // Widen the request vector to the fixed width the package search expects
  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req;
  end

  // Search from the requester after the previous winner and encode the result
  always_comb begin
    pick      = rr_search(req_pad, int'(last_grant), NUM_REQ);
    any_valid = |req;
    grant_oh  = '0;
    grant_idx = '0;
    if (pick >= 0) begin
      grant_oh[pick] = 1'b1;
      grant_idx      = ID_WIDTH'(pick);
    end
  end

endmodule

// File: rtl/util_cdc_arb.sv
// Arbitrates NUM_REQ requesters onto one 4-phase CDC handshake channel.
// ch_rcv arrives already synchronised; no synchroniser lives in here.
module util_cdc_arb
  import util_cdc_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          ch_send,
  output logic [DATA_WIDTH-1:0]         ch_data,
  output logic [ID_WIDTH-1:0]           ch_id,
  input  logic                          ch_rcv,
  output logic                          busy,
  output logic                          done,
  output logic [ID_WIDTH-1:0]           done_id,
  output logic [15:0]                   xfer_cnt
);

  arb_state_e              state_q, state_d;
  logic [ID_WIDTH-1:0]     last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]     ch_id_q, ch_id_d;
  logic [DATA_WIDTH-1:0]   ch_data_q, ch_data_d;
  logic                    done_q, done_d;
  logic [ID_WIDTH-1:0]     done_id_q, done_id_d;
  logic [15:0]             xfer_cnt_q, xfer_cnt_d;

  logic [NUM_REQ-1:0]      grant_oh;
  logic [ID_WIDTH-1:0]     grant_idx;
  logic                    any_valid;
  logic                    grant_en;
  logic [DATA_WIDTH-1:0]   grant_data;

  util_rr_arb #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant_oh   (grant_oh),
    .grant_idx  (grant_idx),
    .any_valid  (any_valid)
  );

  // A grant needs an idle channel: no stale ack and not the done cycle
  always_comb begin
    grant_en = (state_q == ST_IDLE) && any_valid && !ch_rcv && !done_q;
  end

  // Mux the winner's payload out of the flattened request bus
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // State and datapath registers; reset abandons any transfer in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      ch_id_q      <= '0;
      ch_data_q    <= '0;
      done_q       <= 1'b0;
      done_id_q    <= '0;
      xfer_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ch_id_q      <= ch_id_d;
      ch_data_q    <= ch_data_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  // Next-state: walk the 4-phase handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (grant_en) state_d = ST_SEND;
      ST_SEND:    if (ch_rcv)   state_d = ST_RELEASE;
      ST_RELEASE: if (!ch_rcv)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: capture on grant, count and pulse on completion
  always_comb begin
    last_grant_d = last_grant_q;
    ch_id_d      = ch_id_q;
    ch_data_d    = ch_data_q;
    if (grant_en) begin
      last_grant_d = grant_idx;
      ch_id_d      = grant_idx;
      ch_data_d    = grant_data;
    end
    done_d     = (state_q == ST_RELEASE) && !ch_rcv;
    done_id_d  = done_d ? ch_id_q : done_id_q;
    xfer_cnt_d = xfer_cnt_q + 16'(done_d);
  end

  // Outputs; req_ready is forced low while reset is held
  always_comb begin
    req_ready = (grant_en && rstn) ? grant_oh : '0;
    ch_send   = (state_q == ST_SEND);
    busy      = (state_q != ST_IDLE);
    ch_data   = ch_data_q;
    ch_id     = ch_id_q;
    done      = done_q;
    done_id   = done_id_q;
    xfer_cnt  = xfer_cnt_q;
  end

endmodule

// File: tb/tb_util_cdc_arb.sv
// Bench for util_cdc_arb: directed scenarios with literal expectations, then
// randomized requesters and ack timing against a transaction-level model.
module tb_util_cdc_arb;

  localparam int NUM = 4;
  localparam int DW  = 32;
  localparam int IW  = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NUM-1:0]    req_valid = '0;
  logic [NUM*DW-1:0] req_data = '0;
  logic              ch_rcv = 1'b0;
  logic [NUM-1:0]    req_ready;
  logic              ch_send;
  logic [DW-1:0]     ch_data;
  logic [IW-1:0]     ch_id;
  logic              busy;
  logic              done;
  logic [IW-1:0]     done_id;
  logic [15:0]       xfer_cnt;

  util_cdc_arb #(.NUM_REQ(NUM), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ch_send(ch_send), .ch_data(ch_data),
    .ch_id(ch_id), .ch_rcv(ch_rcv), .busy(busy), .done(done),
    .done_id(done_id), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Round-robin rule: first valid requester after the last winner
  function automatic int pick(input logic [NUM-1:0] v, input int last);
    for (int k = 1; k <= NUM; k++) begin
      int idx;
      idx = (last + k) % NUM;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- transaction-level model ----------------
  bit          m_busy, m_acked, m_done;
  int          m_id, m_last, m_done_id;
  logic [DW-1:0] m_data;
  logic [15:0] m_cnt;
  bit          preload_pulse = 1'b0;
  int          mg;
  bit          m_grant, m_finish;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 0; m_acked = 0; m_done = 0;
      m_id = 0; m_last = NUM - 1; m_done_id = 0;
      m_data = '0; m_cnt = '0;
    end else begin
      mg       = pick(req_valid, m_last);
      m_grant  = !m_busy && !m_done && !ch_rcv && (mg >= 0);
      m_finish = m_busy && m_acked && !ch_rcv;
      if (m_busy) begin
        if (!m_acked) begin
          if (ch_rcv) m_acked = 1;
        end else if (!ch_rcv) begin
          m_busy = 0; m_acked = 0;
        end
      end else if (m_grant) begin
        m_busy = 1; m_acked = 0; m_id = mg; m_last = mg;
        m_data = req_data[mg*DW +: DW];
      end
      if (m_finish) begin
        m_done_id = m_id;
        m_cnt     = m_cnt + 16'd1;
      end
      if (preload_pulse) m_cnt = 16'hFFFF;
      m_done = m_finish;
    end
  end

  // Per-cycle comparison of every output against the model
  logic [NUM-1:0] exp_ready;
  int             cg;
  always @(negedge clk) begin
    exp_ready = '0;
    if (rstn && !m_busy && !m_done && !ch_rcv) begin
      cg = pick(req_valid, m_last);
      if (cg >= 0) exp_ready[cg] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("ch_send", 64'(ch_send), 64'(m_busy && !m_acked));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
    chk("ch_data", 64'(ch_data), 64'(m_data));
    chk("ch_id", 64'(ch_id), 64'(m_id));
    if (m_done || !rstn) chk("done_id", 64'(done_id), 64'(m_done_id));
  end

  // ---------------- channel responder ----------------
  // rmode 0: ch_rcv = rcv_force; 1: ack after rdelay cycles; 2: random
  int rmode = 0;
  int rdelay = 0;
  int wcnt = 0;
  bit rcv_force = 1'b0;

  initial begin
    forever begin
      @(posedge clk); #2;
      case (rmode)
        0: ch_rcv = rcv_force;
        1: begin
          if (ch_send && !ch_rcv) begin
            if (wcnt >= rdelay) ch_rcv = 1'b1;
            else wcnt++;
          end else if (!ch_send && ch_rcv) begin
            ch_rcv = 1'b0;
          end else if (!ch_send) begin
            wcnt = 0;
          end
        end
        default: begin
          if (ch_send) begin
            if (!ch_rcv && $urandom_range(1) == 0) ch_rcv = 1'b1;
          end else if (ch_rcv) begin
            if ($urandom_range(1) == 0) ch_rcv = 1'b0;
          end else if (!busy && $urandom_range(15) == 0) begin
            ch_rcv = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic wait_ready(input int bound, output int idx, output int at);
    idx = -1; at = 0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < NUM; i++) if (req_ready[i]) idx = i;
        at = cyc;
        return;
      end
    end
    chk("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        return;
      end
    end
    chk("done_timeout", 64'd0, 64'd1);
  endtask

  int idx, at, prev_at, sends;
  bit seen, stable, early;
  int exp_order[5] = '{0, 1, 2, 3, 0};
  logic [NUM-1:0] acc;

  initial begin
    // ---- single request ----
    do_reset();
    req_data[0 +: DW] = 32'hA5A5A5A5;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t1_send", 64'(ch_send), 64'd1);
    chk("t1_data", 64'(ch_data), 64'hA5A5A5A5);
    chk("t1_id", 64'(ch_id), 64'd0);
    rmode = 1; rdelay = 0;
    wait_done(10, seen);
    chk("t1_done_id", 64'(done_id), 64'd0);
    chk("t1_cnt", 64'(xfer_cnt), 64'd1);
    tick();

    // ---- all four valid: fair order and 4-cycle spacing ----
    do_reset();
    for (int i = 0; i < NUM; i++) req_data[i*DW +: DW] = 32'h1000 + i;
    req_valid = 4'hF;
    prev_at = 0;
    for (int n = 0; n < 5; n++) begin
      wait_ready(20, idx, at);
      chk("t2_order", 64'(idx), 64'(exp_order[n]));
      if (n > 0) chk("t2_gap", 64'(at - prev_at), 64'd4);
      prev_at = at;
    end
    tick();
    req_valid = '0;
    wait_done(20, seen);
    tick();

    // ---- slow ack: ch_send held, data stable ----
    rdelay = 10;
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    req_valid = 4'b0100;
    wait_ready(20, idx, at);
    chk("t3_idx", 64'(idx), 64'd2);
    tick();
    req_valid = '0;
    sends = 0; stable = 1; early = 0; seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (ch_send) begin
        sends++;
        if (ch_data !== 32'hDEADBEEF) stable = 0;
      end
      if (done && ch_rcv) early = 1;
      if (done) seen = 1;
    end
    chk("t3_send_cycles", 64'(sends), 64'd11);
    chk("t3_stable", 64'(stable), 64'd1);
    chk("t3_early_done", 64'(early), 64'd0);
    chk("t3_done_seen", 64'(seen), 64'd1);
    tick();

    // ---- stale ack blocks grant ----
    rmode = 0; rcv_force = 1'b1;
    req_valid = 4'b0010;
    repeat (5) begin
      @(negedge clk);
      chk("t4_blocked", 64'(req_ready), 64'd0);
    end
    tick();
    rcv_force = 1'b0;
    @(negedge clk);
    chk("t4_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    rmode = 1; rdelay = 0;
    wait_done(20, seen);
    tick();

    // ---- reset during SEND ----
    rmode = 0; rcv_force = 1'b0;
    req_data[2*DW +: DW] = 32'h77;
    req_valid = 4'b0100;
    wait_ready(10, idx, at);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t5_send_before", 64'(ch_send), 64'd1);
    #1 rstn = 1'b0;
    #1;
    chk("t5_send_rst", 64'(ch_send), 64'd0);
    chk("t5_busy_rst", 64'(busy), 64'd0);
    chk("t5_cnt_rst", 64'(xfer_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    req_valid = 4'hF;
    @(negedge clk);
    chk("t5_first", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    rmode = 1; rdelay = 0;
    wait_done(20, seen);
    tick();

    // ---- counter wrap ----
    @(negedge clk);
    #1 force dut.xfer_cnt_q = 16'hFFFF;
    #1 release dut.xfer_cnt_q;
    preload_pulse = 1'b1;
    @(posedge clk); #1 preload_pulse = 1'b0;
    @(negedge clk);
    chk("t6_pre", 64'(xfer_cnt), 64'hFFFF);
    tick();
    req_valid = 4'b0001;
    wait_ready(10, idx, at);
    tick();
    req_valid = '0;
    wait_done(20, seen);
    chk("t6_wrap", 64'(xfer_cnt), 64'd0);
    tick();

    // ---- randomized traffic ----
    rmode = 2;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NUM; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        else if (req_valid[i]) begin
          if ($urandom_range(31) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*DW +: DW] = $urandom;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/util_cdc_arb.md
UTIL_CDC_ARB -- requirements
Module: util_cdc_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters, SHALL be legal in the range 2..16.
REQ-002 Parameter DATA_WIDTH, default 32, payload width per requester.
REQ-003 Parameter ID_WIDTH, default 4, width of requester index, SHALL satisfy 2**ID_WIDTH >= NUM_REQ.
REQ-004 clk  input  1  single clock; every port is synchronous to it.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester transfer request; held until accepted.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ  one-hot acceptance pulse; req_valid[i] & req_ready[i] = accepted.
REQ-009 ch_send  output  1  handshake send to the downstream CDC handshake channel.
REQ-010 ch_data  output  DATA_WIDTH  payload to the channel; stable while ch_send=1.
REQ-011 ch_id  output  ID_WIDTH  index of the requester that owns the current transfer.
REQ-012 ch_rcv  input  1  channel receive acknowledge, already synchronised into clk.
REQ-013 busy  output  1  high whenever state != IDLE.
REQ-014 done  output  1  one-cycle pulse at transfer completion.
REQ-015 done_id  output  ID_WIDTH  requester index qualified by done.
REQ-016 xfer_cnt  output  16  count of completed transfers, wraps 0xFFFF->0.

Function
REQ-017 FSM states SHALL be IDLE, SEND, RELEASE.
REQ-018 IDLE, any req_valid high: round-robin grant, search starting at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1 so requester 0 has first priority.
REQ-019 Grant cycle: req_ready[g] pulses exactly one cycle; req_data[g] latched into ch_data, g into ch_id; next state SEND.
REQ-020 SEND: ch_send=1 from the cycle after the grant; stays 1 until ch_rcv sampled high, then next state RELEASE with ch_send=0 in that next cycle.
REQ-021 RELEASE: ch_send=0; wait for ch_rcv sampled low, then pulse done for one cycle with done_id=ch_id, increment xfer_cnt, return to IDLE.
REQ-022 Grant-to-done minimum latency SHALL be 3 cycles when ch_rcv rises one cycle after ch_send and falls one cycle after ch_send falls.
REQ-023 No arbitration in the done cycle; the next grant is made at the earliest in the cycle after done, giving a minimum of 4 cycles per transfer.
REQ-024 ch_data/ch_id SHALL hold their value outside SEND/RELEASE until the next grant; they change only on a grant.
REQ-025 req_valid deasserting while not granted is legal and drops that request; requests arriving during a transfer wait for IDLE.
REQ-026 ch_rcv high while in IDLE (stale ack) SHALL block granting until it is low.
REQ-027 req_ready SHALL be all-zero in every cycle except grant cycles.

Reset
REQ-028 rstn low: state=IDLE, ch_send=0, req_ready=0, done=0, busy=0, ch_data=0, ch_id=0, done_id=0, xfer_cnt=0, last_grant=NUM_REQ-1, all asynchronous.
REQ-029 Reset mid-transfer SHALL abandon the transfer without a done pulse; release is synchronous to clk.

Structure
REQ-030 State encoding constants and the round-robin search function SHALL live in shared package util_cdc_pkg.
REQ-031 A sub-module util_rr_arb (request vector, last grant -> one-hot grant, index, any-valid) SHALL hold the arbitration logic.
REQ-032 The block SHALL connect directly to util_cdc-family handshake channels; no synchroniser SHALL exist inside.

Verification
REQ-033 Single request: req_valid=0001, data 0xA5A5A5A5 -> req_ready[0] pulse, ch_send next cycle, ch_data=0xA5A5A5A5, ch_id=0, done with done_id=0, xfer_cnt=1.
REQ-034 All four valid continuously -> grant order 0,1,2,3,0, with no requester granted twice before the others.
REQ-035 ch_rcv delayed 10 cycles -> ch_send held 1 with ch_data stable for all 10 cycles; no done until ch_rcv falls.
REQ-036 ch_rcv stuck high in IDLE with req_valid=0010 -> no grant; grant occurs one cycle after ch_rcv falls.
REQ-037 rstn asserted during SEND -> ch_send=0 immediately, no done, xfer_cnt=0, next grant goes to requester 0.
REQ-038 Preload xfer_cnt to 0xFFFF, then complete one transfer -> xfer_cnt=0x0000.
